i2c_sccb_arbiter: RTL
=====================

Name: i2c_sccb_arbiter

Overview:
- Shares the single SCCB/I2C master (exec/done handshake, 16-bit {reg_addr, reg_data} word) between two requesters.
- Port A is the power-up register-table sequencer. Port B is the runtime tuning path (exposure/gain read-modify-write from the gesture pipeline).
- Fixed priority to A, with an anti-starvation limit for B, a per-transaction watchdog, and per-port response routing.
- Sits between the requesters and the I2C master, all in the 1 MHz I2C control clock domain.

Parameters:
- TIMEOUT_CYC, 1023: clk cycles allowed in WAIT before a transaction is aborted (1.023 ms at 1 MHz).
- STARVE_LIM, 4: consecutive A grants allowed while B is pending before B is forced one grant.

Ports:
- clk  in  1  I2C control clock, 1 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- a_exec  in  1  port A request pulse, one cycle.
- a_data  in  16  port A {reg_addr, wdata}; sampled on a_exec.
- a_rh_wl  in  1  port A direction: 1 = read, 0 = write; sampled on a_exec.
- a_done  out  1  port A completion pulse, one cycle.
- a_rdata  out  8  port A read data; valid with a_done.
- a_err  out  1  port A NACK or timeout flag; valid with a_done.
- b_exec, b_data, b_rh_wl, b_done, b_rdata, b_err: same as port A, for port B.
- b_en  in  1  port B enable; tie to init_done.
- ovf  out  2  sticky dropped-request flags: [0] = A, [1] = B.
- i2c_exec  out  1  master start pulse.
- i2c_data  out  16  master {addr, data}.
- i2c_rh_wl  out  1  master direction.
- i2c_done  in  1  master completion pulse.
- i2c_rdata  in  8  master read byte.
- i2c_nack  in  1  master NACK flag, valid with i2c_done.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags, latched requests and starvation counter cleared.
- Reset applies immediately mid-transaction. A later stray i2c_done is ignored.
- Pending latches:
  - x_exec sets pend_x and captures x_data and x_rh_wl.
  - x_exec while pend_x is set, or while port x is granted and not yet done, is dropped and sets ovf[x]. ovf stays set until reset.
  - x_exec in the same cycle as x_done is accepted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE grant rules:
  - pend_a and !(pend_b & b_en & starve_cnt == STARVE_LIM): grant A.
  - Else if pend_b & b_en: grant B.
  - On grant: load i2c_data and i2c_rh_wl from the winner, clear its pend flag, go to ISSUE.
  - pend_b with b_en = 0 stays pending and is never granted.
- starve_cnt:
  - Increments on each A grant while pend_b & b_en; saturates at STARVE_LIM.
  - Clears on any B grant, or on an A grant with B not pending.
- ISSUE: i2c_exec = 1 for exactly one cycle; go to WAIT and clear the timeout counter.
- WAIT, on i2c_done:
  - Capture i2c_rdata (forced to 0 for writes) and i2c_nack; go to RESP.
- WAIT, when the counter reaches TIMEOUT_CYC-1 with no i2c_done:
  - err = 1, rdata = 0; go to RESP.
- RESP: x_done = 1 for one cycle on the granted port, x_err = captured flag, x_rdata driven; go to IDLE.
- x_rdata and x_err hold their values until that port's next done.
- i2c_done outside WAIT is ignored.
- Timing: exec on an idle bus at edge n gives grant at n+1, i2c_exec high in cycle n+2, and x_done one cycle after the captured i2c_done.
- i2c_data and i2c_rh_wl stay stable from ISSUE through RESP.
- Simultaneous a_exec and b_exec: both latch; A is served first unless the starve limit has been reached.

Decomposition:
- Shared package i2c_pkg:
  - state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3);
  - port index constants PORT_A = 0, PORT_B = 1;
  - I2C word field positions ADDR_MSB = 15, DATA_MSB = 7.
- Natural sub-module: i2c_req_latch, instantiated once per port. It holds the pend flag, the captured request and overflow detection.

Test Plan:
1. A write, idle bus: a_exec with a_data = 16'h1280, a_rh_wl = 0 -> i2c_exec in cycle n+2 with i2c_data = 16'h1280; i2c_done with nack = 0 -> a_done one cycle later, a_err = 0, a_rdata = 0.
2. B read with b_en = 1: b_data = 16'h1000, master returns i2c_rdata = 8'h5A -> b_done, b_rdata = 8'h5A; a_done stays 0.
3. Gating: b_exec with b_en = 0 -> no i2c_exec for 100 cycles; raise b_en -> B issued within 2 cycles.
4. Starvation, STARVE_LIM = 4: B pending, A re-requests on every a_done -> grant order is A, A, A, A, B, A; both ports' data matches on the master bus.
5. Watchdog: master never returns done -> a_done exactly TIMEOUT_CYC cycles after WAIT entry, a_err = 1; a stray i2c_done afterwards produces no extra done pulse.
6. Overflow and reset: second a_exec while A is pending -> ovf = 2'b01 and only one transaction issued; rst_n low during WAIT -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, port indices and word field positions for the SCCB arbiter
package i2c_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam int ADDR_MSB = 15;
    localparam int DATA_MSB = 7;
endpackage

// File: rtl/i2c_req_latch.sv
// i2c_req_latch: per-port pending flag, captured request and sticky overflow detection
module i2c_req_latch
    import i2c_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exec,
    input  logic [15:0] data,
    input  logic        rh_wl,
    input  logic        active,
    input  logic        done,
    input  logic        clr,
    output logic        pend,
    output logic [15:0] q_data,
    output logic        q_rh_wl,
    output logic        ovf
);
    logic drop;
    assign drop = exec & (pend | (active & !done));
    // accept a request unless one is already queued or in flight; a request in the done cycle is accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend    <= 1'b0;
            q_data  <= '0;
            q_rh_wl <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ovf <= ovf | drop;
            if (exec & !drop) begin
                pend    <= 1'b1;
                q_data  <= data;
                q_rh_wl <= rh_wl;
            end else if (clr)
                pend <= 1'b0;
        end
endmodule

// File: rtl/i2c_sccb_arbiter.sv
// i2c_sccb_arbiter: shares one SCCB/I2C master between the init sequencer (A) and runtime tuning (B)
module i2c_sccb_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int STARVE_LIM  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_exec,
    input  logic [15:0] a_data,
    input  logic        a_rh_wl,
    output logic        a_done,
    output logic [7:0]  a_rdata,
    output logic        a_err,
    input  logic        b_exec,
    input  logic [15:0] b_data,
    input  logic        b_rh_wl,
    output logic        b_done,
    output logic [7:0]  b_rdata,
    output logic        b_err,
    input  logic        b_en,
    output logic [1:0]  ovf,
    output logic        i2c_exec,
    output logic [15:0] i2c_data,
    output logic        i2c_rh_wl,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_rdata,
    input  logic        i2c_nack,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    state_t state, state_nx;
    logic gnt, pend_a, pend_b, qa_rh, qb_rh, grant_a, grant_b, timeout, finish;
    logic [15:0] qa_data, qb_data;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] starve_cnt;
    logic [7:0] rd_val;
    logic err_val;

    i2c_req_latch u_lat_a (
        .clk(clk), .rst_n(rst_n), .exec(a_exec), .data(a_data), .rh_wl(a_rh_wl),
        .active(busy & gnt == PORT_A), .done(a_done), .clr(grant_a),
        .pend(pend_a), .q_data(qa_data), .q_rh_wl(qa_rh), .ovf(ovf[0])
    );
    i2c_req_latch u_lat_b (
        .clk(clk), .rst_n(rst_n), .exec(b_exec), .data(b_data), .rh_wl(b_rh_wl),
        .active(busy & gnt == PORT_B), .done(b_done), .clr(grant_b),
        .pend(pend_b), .q_data(qb_data), .q_rh_wl(qb_rh), .ovf(ovf[1])
    );

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // grant arbitration, watchdog expiry, next state and handshake outputs
    always_comb begin
        grant_a  = state == IDLE & pend_a & !(pend_b & b_en & starve_cnt == SW'(STARVE_LIM));
        grant_b  = state == IDLE & !grant_a & pend_b & b_en;
        timeout  = state == WAIT & !i2c_done & tcnt == TW'(TIMEOUT_CYC - 1);
        finish   = state == WAIT & (i2c_done | timeout);
        rd_val   = (i2c_done & i2c_rh_wl) ? i2c_rdata : 8'h00;
        err_val  = i2c_done ? i2c_nack : 1'b1;
        state_nx = state == IDLE  ? ((grant_a | grant_b) ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (finish ? RESP : WAIT) : IDLE;
        i2c_exec = state == ISSUE;
        busy     = state != IDLE;
        a_done   = state == RESP & gnt == PORT_A;
        b_done   = state == RESP & gnt == PORT_B;
    end

    // master word load on grant, starvation count, watchdog counter and per-port response capture
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            gnt        <= PORT_A;
            i2c_data   <= '0;
            i2c_rh_wl  <= 1'b0;
            starve_cnt <= '0;
            tcnt       <= '0;
            a_rdata    <= '0;
            a_err      <= 1'b0;
            b_rdata    <= '0;
            b_err      <= 1'b0;
        end else begin
            if (grant_a) begin
                gnt        <= PORT_A;
                i2c_data   <= qa_data;
                i2c_rh_wl  <= qa_rh;
                starve_cnt <= !(pend_b & b_en) ? '0 :
                              starve_cnt == SW'(STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
            end else if (grant_b) begin
                gnt        <= PORT_B;
                i2c_data   <= qb_data;
                i2c_rh_wl  <= qb_rh;
                starve_cnt <= '0;
            end
            tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
            if (finish & gnt == PORT_A) begin
                a_rdata <= rd_val;
                a_err   <= err_val;
            end
            if (finish & gnt == PORT_B) begin
                b_rdata <= rd_val;
                b_err   <= err_val;
            end
        end
endmodule
